// File: rtl/bsg_manycore_pkg.sv
// bsg_manycore_pkg: shared manycore address types, field widths and helpers.
//   eva_kind_e                      classification of a reconstructed EVA
//   bsg_manycore_global_addr_s      {2'b01, y, x, word addr, 2'b00}
//   bsg_manycore_tile_group_addr_s  {3'b001, y, x, word addr, 2'b00}
package bsg_manycore_pkg;
  typedef enum logic [1:0] {
    e_eva_dram       = 2'd0,
    e_eva_global     = 2'd1,
    e_eva_tile_group = 2'd2,
    e_eva_invalid    = 2'd3
  } eva_kind_e;
  localparam int global_x_cord_width_gp = 7;
  localparam int global_y_cord_width_gp = 7;
  localparam int global_epa_word_addr_width_gp = 14;
  localparam int tile_group_x_cord_width_gp = 6;
  localparam int tile_group_y_cord_width_gp = 6;
  localparam int tile_group_epa_word_addr_width_gp = 15;
  typedef struct packed {
    logic [1:0]                                 remote;
    logic [global_y_cord_width_gp-1:0]          y_cord;
    logic [global_x_cord_width_gp-1:0]          x_cord;
    logic [global_epa_word_addr_width_gp-1:0]   addr;
    logic [1:0]                                 low_bits;
  } bsg_manycore_global_addr_s;
  typedef struct packed {
    logic [2:0]                                 remote;
    logic [tile_group_y_cord_width_gp-1:0]      y_cord;
    logic [tile_group_x_cord_width_gp-1:0]      x_cord;
    logic [tile_group_epa_word_addr_width_gp-1:0] addr;
    logic [1:0]                                 low_bits;
  } bsg_manycore_tile_group_addr_s;
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction
endpackage

// File: rtl/bsg_manycore_dram_hash_inverse.sv
// bsg_manycore_dram_hash_inverse: rebuilds the DRAM EVA for an NPA that names a
// vcache in the pod directly north or south of the requester's pod.
//   x_cord_i/y_cord_i  {pod, sub} target coordinate
//   epa_i              word EPA inside the vcache
//   pod_x_i/pod_y_i    requester's pod
//   hit_o              coordinate is a vcache of the requester's north/south pod
//   fit_o              EPA line index fits the EVA line field
//   eva_o              {1, line, row id, x_sub, block offset, 2'b00}
module bsg_manycore_dram_hash_inverse
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int pod_x_cord_width_p = 3,
  parameter int pod_y_cord_width_p = 3,
  parameter int num_tiles_x_p = 4,
  parameter int num_tiles_y_p = 4,
  parameter int num_vcache_rows_p = 2,
  parameter int vcache_block_size_in_words_p = 8
) (
  input  logic [x_cord_width_p-1:0]     x_cord_i,
  input  logic [y_cord_width_p-1:0]     y_cord_i,
  input  logic [addr_width_p-1:0]       epa_i,
  input  logic [pod_x_cord_width_p-1:0] pod_x_i,
  input  logic [pod_y_cord_width_p-1:0] pod_y_i,
  output logic                          hit_o,
  output logic                          fit_o,
  output logic [data_width_p-1:0]       eva_o
);
  localparam int x_sub_w = safe_clog2(num_tiles_x_p);
  localparam int y_sub_w = safe_clog2(num_tiles_y_p);
  localparam int row_w = safe_clog2(2 * num_vcache_rows_p);
  localparam int blk_w = $clog2(vcache_block_size_in_words_p);
  localparam int hi_w = data_width_p - 3 - row_w - x_sub_w - blk_w;
  logic [pod_x_cord_width_p-1:0] pod_x;
  logic [pod_y_cord_width_p-1:0] pod_y;
  logic [x_sub_w-1:0] x_sub;
  logic [y_sub_w-1:0] y_sub;
  logic [addr_width_p-blk_w-1:0] epa_hi;
  logic [row_w-1:0] row;
  logic north, south;
  assign pod_x = x_cord_i[x_cord_width_p-1:x_sub_w];
  assign pod_y = y_cord_i[y_cord_width_p-1:y_sub_w];
  assign x_sub = x_cord_i[x_sub_w-1:0];
  assign y_sub = y_cord_i[y_sub_w-1:0];
  // neighbour pods must not wrap around the pod_y range
  assign north = pod_y_i != '0 && pod_y == pod_y_i - pod_y_cord_width_p'(1);
  assign south = pod_y_i != '1 && pod_y == pod_y_i + pod_y_cord_width_p'(1);
  assign hit_o = pod_x == pod_x_i && (north || south) && 32'(y_sub) < num_vcache_rows_p;
  // north rows are numbered from the pod edge inward on even ids, south rows on odd ids
  assign row = row_w'(north ? 2 * (num_vcache_rows_p - 1 - int'(y_sub)) : 2 * int'(y_sub) + 1);
  assign epa_hi = epa_i[addr_width_p-1:blk_w];
  assign fit_o = (epa_hi >> hi_w) == '0;
  assign eva_o = {1'b1, hi_w'(epa_hi), row, x_sub, epa_i[blk_w-1:0], 2'b00};
endmodule

// File: rtl/bsg_manycore_npa_to_eva.sv
// bsg_manycore_npa_to_eva: two-stage NPA -> byte EVA translator with invalid counter.
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   v_i/ready_o                 NPA handshake (x_cord_i, y_cord_i, epa_i, pod_x_i, pod_y_i, tgo_x_i, tgo_y_i)
//   v_o/yumi_i                  result handshake (eva_o, kind_o)
//   invalid_count_o             saturating count of retired INVALID results
// Optional feature: define BSG_MANYCORE_NPA_TO_EVA_TG_EN to emit TILE_GROUP EVAs for
// NPAs inside the requester's pod at or beyond the tile-group origin.
module bsg_manycore_npa_to_eva
  import bsg_manycore_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int x_cord_width_p = 5,
  parameter int y_cord_width_p = 5,
  parameter int pod_x_cord_width_p = 3,
  parameter int pod_y_cord_width_p = 3,
  parameter int num_tiles_x_p = 4,
  parameter int num_tiles_y_p = 4,
  parameter int num_vcache_rows_p = 2,
  parameter int vcache_block_size_in_words_p = 8,
  parameter int invalid_ctr_width_p = 16,
  localparam int x_sub_w = safe_clog2(num_tiles_x_p),
  localparam int y_sub_w = safe_clog2(num_tiles_y_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           v_i,
  output logic                           ready_o,
  input  logic [x_cord_width_p-1:0]      x_cord_i,
  input  logic [y_cord_width_p-1:0]      y_cord_i,
  input  logic [addr_width_p-1:0]        epa_i,
  input  logic [pod_x_cord_width_p-1:0]  pod_x_i,
  input  logic [pod_y_cord_width_p-1:0]  pod_y_i,
  input  logic [x_sub_w-1:0]             tgo_x_i,
  input  logic [y_sub_w-1:0]             tgo_y_i,
  output logic                           v_o,
  input  logic                           yumi_i,
  output logic [data_width_p-1:0]        eva_o,
  output logic [1:0]                     kind_o,
  output logic [invalid_ctr_width_p-1:0] invalid_count_o
);
  typedef struct packed {
    logic [x_cord_width_p-1:0]     x;
    logic [y_cord_width_p-1:0]     y;
    logic [addr_width_p-1:0]       epa;
    logic [pod_x_cord_width_p-1:0] pod_x;
    logic [pod_y_cord_width_p-1:0] pod_y;
    logic [x_sub_w-1:0]            tgo_x;
    logic [y_sub_w-1:0]            tgo_y;
  } npa_s;
  npa_s s1_q, s1_d;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d, s2_en;
  logic [data_width_p-1:0] eva_q, eva_d, dram_eva, tg_eva, cls_eva;
  eva_kind_e kind_q, kind_d, cls_kind;
  logic [invalid_ctr_width_p-1:0] cnt_q, cnt_d;
  logic dram_hit, dram_fit, glb_fit, tg_hit;
  bsg_manycore_global_addr_s glb;
  bsg_manycore_dram_hash_inverse #(
    .data_width_p(data_width_p), .addr_width_p(addr_width_p),
    .x_cord_width_p(x_cord_width_p), .y_cord_width_p(y_cord_width_p),
    .pod_x_cord_width_p(pod_x_cord_width_p), .pod_y_cord_width_p(pod_y_cord_width_p),
    .num_tiles_x_p(num_tiles_x_p), .num_tiles_y_p(num_tiles_y_p),
    .num_vcache_rows_p(num_vcache_rows_p),
    .vcache_block_size_in_words_p(vcache_block_size_in_words_p)
  ) dram_inv (
    .x_cord_i(s1_q.x), .y_cord_i(s1_q.y), .epa_i(s1_q.epa),
    .pod_x_i(s1_q.pod_x), .pod_y_i(s1_q.pod_y),
    .hit_o(dram_hit), .fit_o(dram_fit), .eva_o(dram_eva)
  );
`ifdef BSG_MANYCORE_NPA_TO_EVA_TG_EN
  logic [x_sub_w-1:0] x_sub;
  logic [y_sub_w-1:0] y_sub;
  bsg_manycore_tile_group_addr_s tg;
  assign x_sub = s1_q.x[x_sub_w-1:0];
  assign y_sub = s1_q.y[y_sub_w-1:0];
  assign tg_hit = s1_q.x[x_cord_width_p-1:x_sub_w] == s1_q.pod_x
               && s1_q.y[y_cord_width_p-1:y_sub_w] == s1_q.pod_y
               && x_sub >= s1_q.tgo_x && y_sub >= s1_q.tgo_y
               && (32'(s1_q.epa) >> tile_group_epa_word_addr_width_gp) == 0;
  assign tg = {3'b001, tile_group_y_cord_width_gp'(y_sub - s1_q.tgo_y),
               tile_group_x_cord_width_gp'(x_sub - s1_q.tgo_x),
               tile_group_epa_word_addr_width_gp'(s1_q.epa), 2'b00};
  assign tg_eva = data_width_p'(tg);
`else
  logic unused_tgo;
  assign tg_hit = 1'b0;
  assign tg_eva = '0;
  assign unused_tgo = ^{s1_q.tgo_x, s1_q.tgo_y};
`endif
  assign glb_fit = (32'(s1_q.x) >> global_x_cord_width_gp) == 0
                && (32'(s1_q.y) >> global_y_cord_width_gp) == 0
                && (32'(s1_q.epa) >> global_epa_word_addr_width_gp) == 0;
  assign glb = {2'b01, global_y_cord_width_gp'(s1_q.y), global_x_cord_width_gp'(s1_q.x),
                global_epa_word_addr_width_gp'(s1_q.epa), 2'b00};
  assign ready_o = !s1_v_q || !s2_v_q || yumi_i;
  assign s2_en = !s2_v_q || yumi_i;
  always_comb begin
    // a vcache coordinate with an oversized EPA is INVALID rather than falling through to GLOBAL
    cls_kind = dram_hit ? (dram_fit ? e_eva_dram : e_eva_invalid)
             : tg_hit ? e_eva_tile_group
             : glb_fit ? e_eva_global : e_eva_invalid;
    cls_eva = cls_kind == e_eva_dram ? dram_eva
            : cls_kind == e_eva_tile_group ? tg_eva
            : cls_kind == e_eva_global ? data_width_p'(glb) : '0;
    s1_v_d = ready_o ? v_i : s1_v_q;
    s1_d = (ready_o && v_i) ? {x_cord_i, y_cord_i, epa_i, pod_x_i, pod_y_i, tgo_x_i, tgo_y_i} : s1_q;
    s2_v_d = s2_en ? s1_v_q : s2_v_q;
    eva_d = (s2_en && s1_v_q) ? cls_eva : eva_q;
    kind_d = (s2_en && s1_v_q) ? cls_kind : kind_q;
    cnt_d = (s2_v_q && yumi_i && kind_q == e_eva_invalid && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q <= '0;
      eva_q <= '0;
      kind_q <= e_eva_invalid;
      cnt_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      s1_q <= s1_d;
      eva_q <= eva_d;
      kind_q <= kind_d;
      cnt_q <= cnt_d;
    end
  assign v_o = s2_v_q;
  assign eva_o = eva_q;
  assign kind_o = kind_q;
  assign invalid_count_o = cnt_q;
endmodule
